asfifo_graydecoder: RTL

- Receive side of a Gray-coded FIFO pointer crossing: samples a Gray count produced in a foreign clock domain and re-times it into the local `clk` domain through a two-stage synchronizer.
- Decodes the synchronized value to binary and reports per-cycle advance, the increment delta and a sticky Gray-violation flag.
- Sits in the asfifo read/write side logic wherever the opposite pointer is needed as a binary count (level computation, full/empty).

---
 rtl/asfifo_graydecoder.sv | 78 +++++++
 1 files changed

// File: rtl/asfifo_graydecoder.sv
// asfifo_graydecoder
//   Receive side of a Gray-coded FIFO pointer crossing. The foreign-domain
//   Gray count is re-timed through a two-stage synchronizer, decoded to
//   binary and reported as a binary count with a per-cycle advance pulse,
//   the modular increment since the previous cycle and a sticky flag that
//   catches consecutive samples differing in more than one bit.
//
// Ports
//   clk         local clock, rising edge
//   rst         synchronous active-low reset
//   gray_in     Gray count from the foreign domain (asynchronous to clk)
//   err_clr     clears the sticky error flag
//   binary_out  decoded binary value of the synchronized Gray count
//   advance     one-cycle pulse when binary_out changed on that edge
//   delta       (new binary_out - previous binary_out) mod 2^width
//   error       sticky multi-bit Gray change indicator

module asfifo_graydecoder #(
    parameter int width = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] gray_in,
    input  logic             err_clr,
    output logic [width-1:0] binary_out,
    output logic             advance,
    output logic [width-1:0] delta,
    output logic             error
);

    localparam logic [width-1:0] one = {{(width-1){1'b0}}, 1'b1};

    logic [width-1:0] s1;
    logic [width-1:0] s2;
    logic [width-1:0] g_q;
    logic [width-1:0] b_new;
    logic [width-1:0] diff;
    logic             viol;

    // Binary bit i is the XOR of all Gray bits from i up to the MSB; written
    // as a reduction of the shifted word so no bit depends on another bit of
    // the same vector.
    always_comb begin
        b_new = '0;
        for (int i = 0; i < width; i++) begin
            b_new[i] = ^(s2 >> i);
        end
    end

    // More than one bit set <=> clearing the lowest set bit leaves a nonzero
    // value.
    always_comb begin
        diff = s2 ^ g_q;
        viol = (diff & (diff - one)) != '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1         <= '0;
            s2         <= '0;
            g_q        <= '0;
            binary_out <= '0;
            advance    <= 1'b0;
            delta      <= '0;
            error      <= 1'b0;
        end else begin
            s1         <= gray_in;
            s2         <= s1;
            g_q        <= s2;
            binary_out <= b_new;
            advance    <= (b_new != binary_out);
            delta      <= b_new - binary_out;
            // A violation in the same cycle as a clear keeps the flag set.
            error      <= viol | (error & ~err_clr);
        end
    end

endmodule
